// File: rtl/mem_b_pkg.sv
// Shared constants and element type for the mem_b B-operand staging memory.
// Optional output register is selected with the MEM_B_OUT_REG_EN macro.
package mem_b_pkg;

    localparam int BITS_AB_DEF = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int IDX_W       = $clog2(DEPTH_DEF);

    typedef logic signed [BITS_AB_DEF-1:0] b_elem_t;

endpackage

// File: rtl/mem_b_if.sv
// Write/stream bus of mem_b: element write port, shift enable and per-column output lanes.
interface mem_b_if
    import mem_b_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int DEPTH   = DEPTH_DEF
);
    localparam int IW = $clog2(DEPTH);

    // No valid/ready: WrEn writes Bin to (row, col) at the posedge it is sampled,
    // en advances every column stream one step, and WrEn blocks the shift that cycle.
    logic                      en;
    logic                      WrEn;
    logic [IW-1:0]             row;
    logic [IW-1:0]             col;
    logic signed [BITS_AB-1:0] Bin;
    logic signed [BITS_AB-1:0] Bout [DEPTH-1:0];

    modport master (output en, WrEn, row, col, Bin, input Bout);
    modport slave  (input en, WrEn, row, col, Bin, output Bout);

endinterface

// File: rtl/mem_b_col.sv
// One skewed column of mem_b: DEPTH+COL slots, slot 0 is the stream head.
// Element (row, COL) lands in slot COL+row, so the column emerges COL shifts late.
module mem_b_col
    import mem_b_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int COL     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  row,
    input  logic [$clog2(DEPTH)-1:0]  col,
    input  logic signed [BITS_AB-1:0] din,
    output logic signed [BITS_AB-1:0] head
);
    localparam int LEN = DEPTH + COL;

    logic signed [BITS_AB-1:0] slot [LEN];
    logic                      wr_hit;
    int                        wr_idx;

    // Out-of-range indices only occur for non power-of-two DEPTH and are dropped.
    assign wr_hit = wr_en && (int'(col) == COL) && (int'(row) < DEPTH);
    assign wr_idx = COL + int'(row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEN; k++) slot[k] <= '0;
        end else if (wr_en) begin
            // Any write anywhere in the matrix suppresses the shift for this cycle.
            for (int k = 0; k < LEN; k++) begin
                if (wr_hit && k == wr_idx) slot[k] <= din;
            end
        end else if (en) begin
            for (int k = 0; k < LEN - 1; k++) slot[k] <= slot[k+1];
            slot[LEN-1] <= '0;
        end
    end

    assign head = slot[0];

endmodule

// File: rtl/mem_b.sv
// mem_b top: DEPTH skewed columns streaming a B matrix as a diagonal wavefront.
// Define MEM_B_OUT_REG_EN to register Bout (one extra cycle of latency).
module mem_b
    import mem_b_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    mem_b_if.slave  bus
);
    logic signed [BITS_AB-1:0] head [DEPTH];

    for (genvar c = 0; c < DEPTH; c++) begin : g_col
        mem_b_col #(
            .BITS_AB (BITS_AB),
            .DEPTH   (DEPTH),
            .COL     (c)
        ) u_col (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .wr_en (bus.WrEn),
            .row   (bus.row),
            .col   (bus.col),
            .din   (bus.Bin),
            .head  (head[c])
        );
    end

`ifdef MEM_B_OUT_REG_EN
    logic signed [BITS_AB-1:0] out_q [DEPTH];

    // Loads on every enabled edge, including ones where a write blocked the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < DEPTH; c++) out_q[c] <= '0;
        end else if (bus.en) begin
            for (int c = 0; c < DEPTH; c++) out_q[c] <= head[c];
        end
    end

    for (genvar c = 0; c < DEPTH; c++) begin : g_out
        assign bus.Bout[c] = out_q[c];
    end
`else
    for (genvar c = 0; c < DEPTH; c++) begin : g_out
        assign bus.Bout[c] = head[c];
    end
`endif

endmodule

// File: tb/tb_mem_b.sv
// Self-checking bench for mem_b: a matrix-plus-shift-count model predicts every lane each cycle.
module tb_mem_b;
    import mem_b_pkg::*;

    localparam int W = 8;
    localparam int D = 8;
`ifdef MEM_B_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_b_if #(.BITS_AB(W), .DEPTH(D)) bus();

    mem_b #(.BITS_AB(W), .DEPTH(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: the matrix as written, and how many shifts it has seen.
    int mdl [D][D];
    int n;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%h) exp=%0d (0x%h) at %0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_lane(input int c);
        int r;
        r = n - LAT - c;
        if (r >= 0 && r < D) return W'(mdl[r][c]);
        return '0;
    endfunction

    task automatic check_lanes(input string tag);
        logic [W-1:0] e;
        for (int c = 0; c < D; c++) exp_q.push_back(model_lane(c));
        for (int c = 0; c < D; c++) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s n=%0d lane%0d", tag, n, c), bus.Bout[c], e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) mdl[r][c] = 0;
        n = 0;
    endtask

    // with_en exercises write-over-shift priority; the registered build keeps en low while loading.
    task automatic write_elem(input int r, input int c, input int v, input bit with_en);
        bus.WrEn = 1'b1;
        bus.row  = IDX_W'(r);
        bus.col  = IDX_W'(c);
        bus.Bin  = W'(v);
        bus.en   = (LAT == 0) ? with_en : 1'b0;
        tick();
        mdl[r][c] = v;
        bus.WrEn = 1'b0;
        bus.en   = 1'b0;
        check_lanes("load");
    endtask

    task automatic stream(input string tag, input int shifts);
        int cyc;
        bit e;
        cyc = 0;
        while (n < shifts && cyc < shifts * 4 + 16) begin
            e = ($urandom_range(0, 3) != 0);
            bus.en = e;
            tick();
            if (e) n++;
            check_lanes(tag);
            cyc++;
        end
        bus.en = 1'b0;
        if (n < shifts) check_val($sformatf("%s shift budget", tag), W'(n), W'(shifts));
    endtask

    task automatic drain(input string tag);
        stream(tag, 2 * D + 1);
        clear_model();
    endtask

    task automatic load_random(input int writes);
        for (int i = 0; i < writes; i++)
            write_elem($urandom_range(0, D-1), $urandom_range(0, D-1),
                       int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        bus.en   = 1'b0;
        bus.WrEn = 1'b0;
        bus.row  = '0;
        bus.col  = '0;
        bus.Bin  = '0;
        clear_model();

        #12;
        check_lanes("in_reset");
        rst_n = 1'b1;
        tick();
        check_lanes("after_reset");

        // Streaming an empty memory must only ever show zeros.
        for (int i = 0; i < 3 * D; i++) begin
            bus.en = 1'b1;
            tick();
            n++;
            check_lanes("empty");
        end
        bus.en = 1'b0;
        clear_model();

        // Ramp matrix B[i][j] = i*8+j.
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) write_elem(r, c, r * 8 + c, 1'b0);
        drain("ramp");

        // Signed extremes in opposite corners.
        write_elem(0, 0, -128, 1'b0);
        write_elem(D-1, D-1, 127, 1'b1);
        drain("extremes");

        // Last write wins.
        write_elem(2, 5, 17, 1'b0);
        write_elem(2, 5, -3, 1'b1);
        drain("rewrite");

        // Random matrices with random write order, overwrites and en overlap.
        for (int t = 0; t < 3; t++) begin
            load_random($urandom_range(40, 90));
            drain($sformatf("rand%0d", t));
        end

        // Asynchronous reset in the middle of a stream.
        load_random(64);
        stream("pre_rst", 4);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_lanes("rst_async");
        #2;
        rst_n = 1'b1;
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
